tx_pulse_decoder: RTL

- Receive-side decoder for the pulse-distance serial line driven by the team's pulse transmitter.
- Sits directly downstream of that transmitter, on the same wire.
- Synchronises the incoming line, measures every high and low interval, validates each one against the sync/bit timing, and reconstructs the WIDTH-bit word, MSB first.
- Presents each word with a one-cycle valid strobe. Malformed frames are flagged and discarded.

---
 rtl/tx_pulse_decoder.sv | 101 ++++++++++
 1 files changed

// File: rtl/tx_pulse_decoder.sv
// tx_pulse_decoder: recovers WIDTH-bit words from the pulse-distance serial line, MSB first,
// validating every high/low interval against the sync/bit windows and timing out stuck levels.
module tx_pulse_decoder #(
  parameter int SBD   = 700,
  parameter int SSD   = 700,
  parameter int BBD   = 400,
  parameter int BSD0  = 200,
  parameter int BSD1  = 400,
  parameter int WIDTH = 8,
  parameter int TOL   = 50
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             signal_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SYNC_H, SYNC_L, BIT_H, BIT_L} state_t;
  state_t state, state_n;
  logic s1, s2, s3, rise, fall, timeout, valid_n, error_n;
  logic [15:0] cnt;
  logic [BW-1:0] bits, bits_n;
  logic [WIDTH-1:0] shift, shift_n, data_n;
  int cnt_i, nom;
  function automatic logic in_win(input int c, input int n);
    return c >= n - TOL && c <= n + TOL;
  endfunction
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign cnt_i = int'({16'b0, cnt});
  assign nom = state == SYNC_H ? SBD : state == SYNC_L ? SSD : state == BIT_H ? BBD : BSD1;
  assign timeout = state != IDLE && !(rise | fall) && cnt_i >= nom + TOL + 1;
  // valid_out is registered while the FSM already sits in IDLE, so it extends busy by that cycle
  assign busy_out = state != IDLE || valid_out;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      state <= IDLE;
      bits <= '0;
      shift <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
      s3 <= s2;
      cnt <= (rise | fall) ? 16'd1 : (cnt == 16'hFFFF ? cnt : cnt + 16'd1);
      state <= state_n;
      bits <= bits_n;
      shift <= shift_n;
      data_out <= data_n;
      valid_out <= valid_n;
      error_out <= error_n;
    end
  end
  always_comb begin
    state_n = state;
    bits_n = bits;
    shift_n = shift;
    data_n = data_out;
    valid_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = SYNC_H;
        bits_n = '0;
      end
      SYNC_H: if (fall) begin
        if (in_win(cnt_i, SBD)) state_n = SYNC_L;
        else error_n = 1'b1;
      end
      SYNC_L: if (rise) begin
        if (in_win(cnt_i, SSD)) state_n = BIT_H;
        else error_n = 1'b1;
      end
      BIT_H: if (fall) begin
        if (!in_win(cnt_i, BBD)) error_n = 1'b1;
        else if (bits == BW'(WIDTH)) begin
          data_n = shift;
          valid_n = 1'b1;
          state_n = IDLE;
        end else state_n = BIT_L;
      end
      BIT_L: if (rise) begin
        if (in_win(cnt_i, BSD0) || in_win(cnt_i, BSD1)) begin
          shift_n = {shift[WIDTH-2:0], in_win(cnt_i, BSD1)};
          bits_n = bits + 1'b1;
          state_n = BIT_H;
        end else error_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (timeout) error_n = 1'b1;
    if (error_n) state_n = IDLE;
  end
endmodule
